muldiv_sequencer: RTL and testbench
===================================

# muldiv_sequencer

Sequences the multiplier and divider on behalf of the main control unit: accepts one MULT/DIV request, pulses the selected unit's start line, waits for its completion, commits the result to HI/LO, and reports completion or an exception. Sits between the control unit and the mult/div units plus the HI/LO select/write path. The control unit raises a request and waits for `done` or `exc`, instead of tracking unit latency itself.

## Interface
- `TIMEOUT_CYCLES`, 64: max cycles in WAIT before a timeout exception; must be ≥ 2 and > worst-case unit latency.
- `CNT_W`, `$clog2(TIMEOUT_CYCLES)`: width of the wait counter.

- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high; sampled on `clk` rising edge.
- `req`  in  1  level request from the control unit; sampled only in IDLE.
- `req_div`  in  1  operation select with `req`: 0 = MULT, 1 = DIV.
- `mult_end`  in  1  multiplier completion pulse.
- `div_end`  in  1  divider completion pulse.
- `div_zero`  in  1  divider divide-by-zero flag.
- `mult_start`  out  1  one-cycle start pulse to the multiplier (MultCtrl).
- `div_start`  out  1  one-cycle start pulse to the divider (DivCtrl).
- `hilo_sel`  out  1  HI/LO input mux select: 0 = mult outputs, 1 = div outputs.
- `hilo_write`  out  1  HI/LO write enable (WriteHILO); one cycle.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse on successful completion.
- `exc`  out  1  one-cycle exception pulse.
- `exc_cause`  out  1  valid with `exc`: 0 = divide-by-zero, 1 = timeout.

## Operation
- States: IDLE, START, WAIT, WRITE, DONE, ERR.
- IDLE: if `req`, latch `req_div` into `op_div`, go to START. Otherwise stay.
- START: assert `mult_start` (op_div=0) or `div_start` (op_div=1) for exactly this cycle. Clear counter. Go to WAIT.
- WAIT, in priority order:
  - (1) op_div and `div_zero`: go to ERR with cause 0, no HI/LO write.
  - (2) End pulse of the selected unit: go to WRITE.
  - (3) Counter == TIMEOUT_CYCLES−1: go to ERR with cause 1.
  - (4) Otherwise increment the counter.
- The non-selected unit's end/zero lines are ignored in all states.
- WRITE: `hilo_write`=1 for one cycle. Go to DONE.
- DONE: `done`=1 for one cycle. Go to IDLE.
- ERR: `exc`=1 and `exc_cause` valid for one cycle. Go to IDLE. HI/LO are never written on an exception.
- `hilo_sel` = `op_div` at all times. It is stable from START through DONE and holds its last value in IDLE.
- `req` outside IDLE is ignored; there is no queueing. A `req` still high in the IDLE cycle after DONE/ERR starts a new operation, so the control unit must drop `req` on `done`/`exc`.
- `done` and `exc` are never high together. `mult_start` and `div_start` are never high together.

## Timing
- Reset: state IDLE, `op_div`=0, counter=0, all outputs 0, applied on the same edge reset is sampled. Reset mid-operation aborts with no `done`, `exc` or `hilo_write`. The units share `reset`.
- With `req` high in IDLE at cycle 0:
  - start pulse in cycle 1;
  - WAIT from cycle 2;
  - end pulse seen in cycle N → `hilo_write` in N+1, `done` in N+2;
  - IDLE in N+3.
- An end pulse in the first WAIT cycle (N=2) is legal: `done` arrives in cycle 4.
- Timeout: with no end, `exc` is asserted in cycle 2+TIMEOUT_CYCLES.
- `div_zero` seen in WAIT cycle N → `exc`, cause 0, in cycle N+1.
- All outputs are registered or decoded directly from the state register; there is no combinational path from inputs to outputs.

## Structure
- Shared package `muldiv_pkg`:
  - state enum `muldiv_state_t`;
  - cause constants `EXC_DIV0`=1'b0, `EXC_TIMEOUT`=1'b1;
  - default `TIMEOUT_CYCLES`.
- One sub-module, `cycle_timer`: clear/enable counter with a terminal-count flag at TIMEOUT_CYCLES−1, parameterised by `CNT_W`.
- The FSM and output decode live in `muldiv_sequencer`.

## Test plan
- MULT, `req`=1/`req_div`=0 at cycle 0, `mult_end` at cycle 34 → `mult_start` cycle 1 only, `hilo_sel`=0, `hilo_write` cycle 35, `done` cycle 36, `busy` cycles 1–36.
- DIV, `req_div`=1, `div_end` at cycle 10 → `div_start` cycle 1, `hilo_sel`=1, `hilo_write` cycle 11, `done` cycle 12, `mult_start` never high.
- DIV, `div_zero` and `div_end` together at cycle 5 → `exc`=1 with `exc_cause`=0 at cycle 6, no `hilo_write`, no `done`.
- MULT with TIMEOUT_CYCLES=8 and no `mult_end` → `exc`=1, `exc_cause`=1 at cycle 10; IDLE at cycle 11.
- MULT with `div_end` pulsed at cycle 4, `req` toggled during WAIT, then `mult_end` at cycle 6 → foreign end and extra `req` ignored, single `done` at cycle 8.
- `reset` at cycle 5 mid-WAIT → all outputs 0 from cycle 6, `busy`=0; a later `mult_end` produces nothing; new `req` at cycle 8 starts normally with start pulse at cycle 9.

Source files
------------

// File: rtl/muldiv_sequencer_pkg.sv
// Shared types and constants for the MULT/DIV sequencer and its timer.
package muldiv_pkg;

  localparam int unsigned TIMEOUT_CYCLES = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_WRITE,
    ST_DONE,
    ST_ERR
  } muldiv_state_t;

  localparam logic EXC_DIV0    = 1'b0;
  localparam logic EXC_TIMEOUT = 1'b1;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Handshake between control unit, mult/div units, HI/LO path and the sequencer.
interface muldiv_sequencer_if;

  logic req;
  logic req_div;
  logic mult_end;
  logic div_end;
  logic div_zero;
  logic mult_start;
  logic div_start;
  logic hilo_sel;
  logic hilo_write;
  logic busy;
  logic done;
  logic exc;
  logic exc_cause;

  modport slave (
    input  req,
    input  req_div,
    input  mult_end,
    input  div_end,
    input  div_zero,
    output mult_start,
    output div_start,
    output hilo_sel,
    output hilo_write,
    output busy,
    output done,
    output exc,
    output exc_cause
  );

  modport master (
    output req,
    output req_div,
    output mult_end,
    output div_end,
    output div_zero,
    input  mult_start,
    input  div_start,
    input  hilo_sel,
    input  hilo_write,
    input  busy,
    input  done,
    input  exc,
    input  exc_cause
  );

endinterface

// File: rtl/muldiv_sequencer_cycle_timer.sv
// Clear/enable wait counter with a terminal-count flag at TIMEOUT_CYCLES-1.
module cycle_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_tc = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/muldiv_sequencer.sv
// Runs one MULT/DIV request: start pulse, wait for unit completion or fault,
// then HI/LO write + done, or a single exception pulse.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = muldiv_pkg::TIMEOUT_CYCLES,
  parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
  input  logic                clk,
  input  logic                reset,
  muldiv_sequencer_if.slave   bus
);

  muldiv_state_t r_state;
  logic          r_op_div;
  logic          r_mult_start;
  logic          r_div_start;
  logic          r_hilo_write;
  logic          r_done;
  logic          r_exc;
  logic          r_exc_cause;

  logic          w_end;
  logic          w_tc;
  logic          w_clr;
  logic          w_en;

  // Only the selected unit's completion line is observed.
  assign w_end = r_op_div ? bus.div_end : bus.mult_end;
  assign w_clr = (r_state == ST_START);
  assign w_en  = (r_state == ST_WAIT);

  cycle_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_clr),
    .i_en  (w_en),
    .o_tc  (w_tc)
  );

  // Pulse outputs are set on the edge entering their state so they are
  // high exactly for that state's single cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_op_div     <= 1'b0;
      r_mult_start <= 1'b0;
      r_div_start  <= 1'b0;
      r_hilo_write <= 1'b0;
      r_done       <= 1'b0;
      r_exc        <= 1'b0;
      r_exc_cause  <= 1'b0;
    end else begin
      r_mult_start <= 1'b0;
      r_div_start  <= 1'b0;
      r_hilo_write <= 1'b0;
      r_done       <= 1'b0;
      r_exc        <= 1'b0;
      r_exc_cause  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.req) begin
            r_op_div     <= bus.req_div;
            r_mult_start <= ~bus.req_div;
            r_div_start  <= bus.req_div;
            r_state      <= ST_START;
          end
        end
        ST_START: begin
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (r_op_div && bus.div_zero) begin
            r_exc       <= 1'b1;
            r_exc_cause <= EXC_DIV0;
            r_state     <= ST_ERR;
          end else if (w_end) begin
            r_hilo_write <= 1'b1;
            r_state      <= ST_WRITE;
          end else if (w_tc) begin
            r_exc       <= 1'b1;
            r_exc_cause <= EXC_TIMEOUT;
            r_state     <= ST_ERR;
          end
        end
        ST_WRITE: begin
          r_done  <= 1'b1;
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        ST_ERR: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.mult_start = r_mult_start;
  assign bus.div_start  = r_div_start;
  assign bus.hilo_sel   = r_op_div;
  assign bus.hilo_write = r_hilo_write;
  assign bus.busy       = (r_state != ST_IDLE);
  assign bus.done       = r_done;
  assign bus.exc        = r_exc;
  assign bus.exc_cause  = r_exc_cause;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer with a per-cycle pulse scoreboard.
module tb_muldiv_sequencer;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  muldiv_sequencer_if b64 ();
  muldiv_sequencer_if b8 ();

  muldiv_sequencer #(.TIMEOUT_CYCLES(64)) dut64 (
    .clk   (clk),
    .reset (reset),
    .bus   (b64)
  );

  muldiv_sequencer #(.TIMEOUT_CYCLES(8), .CNT_W(3)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (b8)
  );

  // Event vector: {mult_start, div_start, hilo_write, done, exc, exc_cause}
  localparam logic [5:0] E_MS = 6'b100000;
  localparam logic [5:0] E_DS = 6'b010000;
  localparam logic [5:0] E_HW = 6'b001000;
  localparam logic [5:0] E_DN = 6'b000100;
  localparam logic [5:0] E_EX = 6'b000010;
  localparam logic [5:0] E_C  = 6'b000001;

  typedef struct {
    int         cyc;
    logic [5:0] ev;
  } exp_t;

  exp_t q64[$];
  exp_t q8[$];

  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   bf64 = -1, bt64 = -2, bf8 = -1, bt8 = -2;
  int   sat64 = 0, sat8 = 0;
  logic sold64 = 1'b0, snew64 = 1'b0, sold8 = 1'b0, snew8 = 1'b0;
  int   b;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, expv);
    end
  endtask

  task automatic push64(input int c, input logic [5:0] e);
    exp_t t;
    t.cyc = c;
    t.ev  = e;
    q64.push_back(t);
  endtask

  task automatic push8(input int c, input logic [5:0] e);
    exp_t t;
    t.cyc = c;
    t.ev  = e;
    q8.push_back(t);
  endtask

  task automatic set_sel64(input logic v);
    sold64 = snew64;
    snew64 = v;
    sat64  = cyc + 1;
  endtask

  task automatic set_sel8(input logic v);
    sold8 = snew8;
    snew8 = v;
    sat8  = cyc + 1;
  endtask

  task automatic step();
    exp_t       t;
    logic [5:0] e;
    @(posedge clk);
    #1;
    cyc++;
    e = '0;
    if (q64.size() > 0 && q64[0].cyc == cyc) begin
      t = q64.pop_front();
      e = t.ev;
    end
    chk("ev64", {2'b00, b64.mult_start, b64.div_start, b64.hilo_write,
                 b64.done, b64.exc, b64.exc_cause}, {2'b00, e});
    chk("busy64", {7'b0, b64.busy}, {7'b0, (cyc >= bf64 && cyc <= bt64)});
    chk("sel64", {7'b0, b64.hilo_sel}, {7'b0, (cyc >= sat64) ? snew64 : sold64});
    e = '0;
    if (q8.size() > 0 && q8[0].cyc == cyc) begin
      t = q8.pop_front();
      e = t.ev;
    end
    chk("ev8", {2'b00, b8.mult_start, b8.div_start, b8.hilo_write,
                b8.done, b8.exc, b8.exc_cause}, {2'b00, e});
    chk("busy8", {7'b0, b8.busy}, {7'b0, (cyc >= bf8 && cyc <= bt8)});
    chk("sel8", {7'b0, b8.hilo_sel}, {7'b0, (cyc >= sat8) ? snew8 : sold8});
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  initial begin
    reset       = 1'b1;
    b64.req     = 1'b0; b64.req_div = 1'b0;
    b64.mult_end = 1'b0; b64.div_end = 1'b0; b64.div_zero = 1'b0;
    b8.req      = 1'b0; b8.req_div = 1'b0;
    b8.mult_end = 1'b0; b8.div_end = 1'b0; b8.div_zero = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();

    // MULT, end at cycle 34
    b = cyc;
    b64.req = 1'b1; b64.req_div = 1'b0;
    push64(b + 1, E_MS); push64(b + 35, E_HW); push64(b + 36, E_DN);
    bf64 = b + 1; bt64 = b + 36; set_sel64(1'b0);
    step();
    b64.req = 1'b0;
    run_to(b + 34);
    b64.mult_end = 1'b1;
    step();
    b64.mult_end = 1'b0;
    run_to(b + 38);

    // DIV, end at cycle 10
    b = cyc;
    b64.req = 1'b1; b64.req_div = 1'b1;
    push64(b + 1, E_DS); push64(b + 11, E_HW); push64(b + 12, E_DN);
    bf64 = b + 1; bt64 = b + 12; set_sel64(1'b1);
    step();
    b64.req = 1'b0;
    run_to(b + 10);
    b64.div_end = 1'b1;
    step();
    b64.div_end = 1'b0;
    run_to(b + 14);

    // DIV, divide-by-zero wins over a simultaneous end
    b = cyc;
    b64.req = 1'b1; b64.req_div = 1'b1;
    push64(b + 1, E_DS); push64(b + 6, E_EX);
    bf64 = b + 1; bt64 = b + 6; set_sel64(1'b1);
    step();
    b64.req = 1'b0;
    run_to(b + 5);
    b64.div_zero = 1'b1; b64.div_end = 1'b1;
    step();
    b64.div_zero = 1'b0; b64.div_end = 1'b0;
    run_to(b + 8);

    // MULT timeout with TIMEOUT_CYCLES=8
    b = cyc;
    b8.req = 1'b1; b8.req_div = 1'b0;
    push8(b + 1, E_MS); push8(b + 10, E_EX | E_C);
    bf8 = b + 1; bt8 = b + 10; set_sel8(1'b0);
    step();
    b8.req = 1'b0;
    run_to(b + 12);

    // MULT with foreign end/zero and req toggling during WAIT
    b = cyc;
    b64.req = 1'b1; b64.req_div = 1'b0;
    push64(b + 1, E_MS); push64(b + 7, E_HW); push64(b + 8, E_DN);
    bf64 = b + 1; bt64 = b + 8; set_sel64(1'b0);
    step();
    b64.req = 1'b0;
    run_to(b + 3);
    b64.req = 1'b1;
    step();
    b64.req = 1'b0; b64.div_end = 1'b1; b64.div_zero = 1'b1;
    step();
    b64.div_end = 1'b0; b64.div_zero = 1'b0; b64.req = 1'b1;
    step();
    b64.req = 1'b0; b64.mult_end = 1'b1;
    step();
    b64.mult_end = 1'b0;
    run_to(b + 10);

    // Reset mid-WAIT, stale end ignored, then a clean restart
    b = cyc;
    b64.req = 1'b1; b64.req_div = 1'b0;
    push64(b + 1, E_MS);
    bf64 = b + 1; bt64 = b + 5; set_sel64(1'b0);
    step();
    b64.req = 1'b0;
    run_to(b + 5);
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    b64.mult_end = 1'b1;
    step();
    b64.mult_end = 1'b0;
    b64.req = 1'b1; b64.req_div = 1'b0;
    push64(b + 9, E_MS); push64(b + 13, E_HW); push64(b + 14, E_DN);
    bf64 = b + 9; bt64 = b + 14;
    step();
    b64.req = 1'b0;
    run_to(b + 12);
    b64.mult_end = 1'b1;
    step();
    b64.mult_end = 1'b0;
    run_to(b + 16);

    chk("q64_left", 8'(q64.size()), 8'd0);
    chk("q8_left", 8'(q8.size()), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
